// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch path: branch opcodes, fetch FSM states, instruction size.
package mips_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_RSVD = 2'b11
  } branch_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-address generator: sequential, branch, jump and JR targets plus redirect arbitration.
// Zero latency; it holds no state and is unaware of back-pressure.
module pc_target_gen
  import mips_pkg::*;
#(
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN-1:0]  EXC_VECTOR = XLEN'(32'h0000_0080)
) (
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     instr_lo,
  input  logic [1:0]      branch_op,
  input  logic            zero,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic [XLEN-1:0] rs_data,
  input  logic            exc_req,
  output logic [XLEN-1:0] pc_inc,
  output logic            redir_vld,
  output logic            redir_exc,
  output logic            misalign,
  output logic [XLEN-1:0] redir_tgt
);

  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic            br_taken;
  branch_op_e      br_op;

  assign br_op    = branch_op_e'(branch_op);
  assign pc_inc   = pc + XLEN'(INSTR_BYTES);
  assign imm_ext  = {{(XLEN-16){instr_lo[15]}}, instr_lo[15:0]};
  assign br_tgt   = pc_inc + (imm_ext << 2);
  assign j_tgt    = {pc_inc[XLEN-1:28], instr_lo[25:0], 2'b00};
  assign br_taken = ((br_op == BR_EQ) && zero) || ((br_op == BR_NE) && !zero);

  // Only a JR that actually wins arbitration can raise a misalignment trap.
  assign misalign  = !exc_req && jump_reg && (rs_data[1:0] != 2'b00);
  assign redir_exc = exc_req || misalign;

  always_comb begin
    redir_vld = 1'b1;
    redir_tgt = pc_inc;
    if (redir_exc) begin
      redir_tgt = EXC_VECTOR;
    end else if (jump_reg) begin
      redir_tgt = rs_data;
    end else if (jump) begin
      redir_tgt = j_tgt;
    end else if (br_taken) begin
      redir_tgt = br_tgt;
    end else begin
      redir_vld = 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request with a one-entry pending-redirect buffer.
// pc updates on the falling edge after valid&ready&!stall; redirects arriving under back-pressure are held, never lost.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]  EXC_VECTOR   = XLEN'(32'h0000_0080)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [1:0]      branch_op,
  input  logic            zero,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic [XLEN-1:0] rs_data,
  input  logic            exc_req,
  input  logic            stall,
  input  logic            imem_req_ready,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err
);

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_nxt;
  logic            redir_vld;
  logic            redir_exc;
  logic            misalign;
  logic            fetching;
  logic            advance;
  logic            unused_instr_hi;

  assign unused_instr_hi = ^instr[31:26];

  pc_target_gen #(
    .XLEN       (XLEN),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_gen (
    .pc        (pc),
    .instr_lo  (instr[25:0]),
    .branch_op (branch_op),
    .zero      (zero),
    .jump      (jump),
    .jump_reg  (jump_reg),
    .rs_data   (rs_data),
    .exc_req   (exc_req),
    .pc_inc    (pc_inc),
    .redir_vld (redir_vld),
    .redir_exc (redir_exc),
    .misalign  (misalign),
    .redir_tgt (redir_tgt)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   imem_req_valid = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign fetching = (state == FETCH);
  assign advance  = fetching && imem_req_ready && !stall;

  // Exceptions pre-empt a buffered transfer; otherwise the older buffered target drains first.
  always_comb begin
    pc_nxt = pc_inc;
    if (redir_exc) begin
      pc_nxt = redir_tgt;
    end else if (pend_valid) begin
      pc_nxt = pend_target;
    end else if (redir_vld) begin
      pc_nxt = redir_tgt;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_VECTOR;
      epc          <= '0;
      misalign_err <= 1'b0;
      pend_valid   <= 1'b0;
      pend_target  <= '0;
    end else if (fetching) begin
      misalign_err <= misalign;
      if (redir_exc) begin
        epc <= misalign ? rs_data : pc;
      end
      if (advance) begin
        pc         <= pc_nxt;
        pend_valid <= 1'b0;
      end else if (redir_vld && (redir_exc || !pend_valid)) begin
        pend_valid  <= 1'b1;
        pend_target <= redir_tgt;
      end
    end else begin
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomised stimulus for pc_fetch_unit, checked every cycle against a queue-based reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [1:0]  branch_op;
  logic        zero, jump, jump_reg, exc_req, stall, imem_req_ready;
  logic [31:0] rs_data;
  logic        imem_req_valid, misalign_err;
  logic [31:0] pc, epc;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .instr          (instr),
    .branch_op      (branch_op),
    .zero           (zero),
    .jump           (jump),
    .jump_reg       (jump_reg),
    .rs_data        (rs_data),
    .exc_req        (exc_req),
    .stall          (stall),
    .imem_req_ready (imem_req_ready),
    .imem_req_valid (imem_req_valid),
    .pc             (pc),
    .epc            (epc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Reference model: pending redirect held in a queue of at most one entry.
  logic [31:0] m_pc, m_epc, m_seq, m_tgt, m_imm;
  logic        m_valid, m_err, m_have, m_exc, m_mis;
  logic [31:0] m_pend[$];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = RV; m_epc = 0; m_err = 0; m_valid = 0;
      m_pend.delete();
    end else if (!m_valid) begin
      m_valid = 1;
    end else begin
      m_seq = m_pc + 4;
      m_imm = {{16{instr[15]}}, instr[15:0]};
      m_have = 1; m_exc = 0; m_mis = 0; m_tgt = 0;
      if (exc_req) begin
        m_tgt = EXC; m_exc = 1;
      end else if (jump_reg) begin
        if (rs_data % 4 != 0) begin m_tgt = EXC; m_exc = 1; m_mis = 1; end
        else m_tgt = rs_data;
      end else if (jump) begin
        m_tgt = (m_seq & 32'hF000_0000) | (32'(instr[25:0]) * 4);
      end else if ((branch_op == 2'd1 && zero) || (branch_op == 2'd2 && !zero)) begin
        m_tgt = m_seq + m_imm * 4;
      end else begin
        m_have = 0;
      end
      m_err = m_mis;
      if (m_exc) m_epc = m_mis ? rs_data : m_pc;
      if (imem_req_ready && !stall) begin
        if (m_exc) m_pc = m_tgt;
        else if (m_pend.size() != 0) m_pc = m_pend[0];
        else if (m_have) m_pc = m_tgt;
        else m_pc = m_seq;
        m_pend.delete();
      end else if (m_have) begin
        if (m_exc) begin
          m_pend.delete();
          m_pend.push_back(m_tgt);
        end else if (m_pend.size() == 0) begin
          m_pend.push_back(m_tgt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    check("model_pc", pc, m_pc);
    check("model_valid", 32'(imem_req_valid), 32'(m_valid));
    check("model_epc", epc, m_epc);
    check("model_misalign", 32'(misalign_err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic [1:0] bop, input logic z, input logic j, input logic jr,
                         input logic [31:0] rs, input logic exc, input logic [31:0] ins);
    branch_op = bop; zero = z; jump = j; jump_reg = jr; rs_data = rs; exc_req = exc; instr = ins;
  endtask

  task automatic idle_ctl();
    set_ctl(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    idle_ctl();
    #3;
    check("reset_pc", pc, RV);
    check("reset_valid", 32'(imem_req_valid), 32'h0);
    check("reset_epc", epc, 32'h0);
    check("reset_misalign", 32'(misalign_err), 32'h0);

    tick(); reset = 1'b1;
    tick(); check("first_fetch_pc", pc, 32'h0);
    check("first_fetch_valid", 32'(imem_req_valid), 32'h1);
    tick(); check("seq_pc_4", pc, 32'h4);
    tick(); check("seq_pc_8", pc, 32'h8);

    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40);
    tick(); check("jump_to_100", pc, 32'h100);
    set_ctl(2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_FFFE);
    tick(); check("beq_taken", pc, 32'h0FC);
    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40);
    tick(); check("jump_back_100", pc, 32'h100);
    set_ctl(2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_FFFE);
    tick(); check("bne_not_taken", pc, 32'h104);

    // Back-pressured jump must be held and delivered exactly once.
    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h80);
    tick(); check("jump_to_200", pc, 32'h200);
    imem_req_ready = 1'b0;
    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40);
    tick(); check("bp_hold_1", pc, 32'h200);
    check("bp_valid_held", 32'(imem_req_valid), 32'h1);
    idle_ctl();
    tick(); check("bp_hold_2", pc, 32'h200);
    imem_req_ready = 1'b1;
    tick(); check("bp_pending_applied", pc, 32'h100);
    tick(); check("bp_no_duplicate", pc, 32'h104);

    // Older buffered JR beats a later J.
    imem_req_ready = 1'b0;
    set_ctl(2'b00, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    tick(); check("conflict_hold_1", pc, 32'h104);
    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h80);
    tick(); check("conflict_hold_2", pc, 32'h104);
    idle_ctl(); imem_req_ready = 1'b1;
    tick(); check("conflict_jr_wins", pc, 32'h400);
    tick(); check("conflict_after", pc, 32'h404);

    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hC0);
    tick(); check("jump_to_300", pc, 32'h300);
    set_ctl(2'b00, 1'b0, 1'b0, 1'b1, 32'h402, 1'b0, 32'h0);
    tick(); check("misalign_pc", pc, EXC);
    check("misalign_epc", epc, 32'h402);
    check("misalign_pulse_hi", 32'(misalign_err), 32'h1);
    idle_ctl();
    tick(); check("misalign_pulse_lo", 32'(misalign_err), 32'h0);
    check("after_misalign_pc", pc, 32'h84);

    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
    tick(); check("exc_pc", pc, EXC);
    check("exc_epc", epc, 32'h84);
    idle_ctl(); stall = 1'b1;
    tick(); check("stall_hold", pc, EXC);
    stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      branch_op = 2'($urandom_range(0, 3));
      zero      = 1'($urandom_range(0, 1));
      jump      = ($urandom_range(0, 7) == 0);
      jump_reg  = ($urandom_range(0, 10) == 0);
      rs_data   = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
      exc_req   = ($urandom_range(0, 29) == 0);
      instr     = $urandom;
      tick();
    end

    // Asynchronous reset between edges with a redirect pending.
    stall = 1'b1; imem_req_ready = 1'b1;
    set_ctl(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40);
    tick();
    idle_ctl();
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc", pc, RV);
    check("async_rst_valid", 32'(imem_req_valid), 32'h0);
    check("async_rst_epc", epc, 32'h0);
    tick(); stall = 1'b0; reset = 1'b1;
    tick(); check("rerelease_pc", pc, RV);
    check("rerelease_valid", 32'(imem_req_valid), 32'h1);
    tick(); check("pend_discarded", pc, 32'h4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and fetch-request block for the MIPS core, replacing the fixed 32-bit branch-only PC. It adds the following on top of PC+4 and BEQ:
- BNE, J and JR targets.
- An exception vector with EPC capture and misaligned-target trapping.
- A valid/ready request handshake to instruction memory, with a one-entry pending-redirect buffer so that control transfers are never lost while fetch is back-pressured or stalled.

It sits between the control/ALU stage and instruction memory.

Parameters:
- XLEN, 32, datapath and address width in bits (min 32).
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (XLEN bits).
- EXC_VECTOR, 32'h0000_0080, exception handler address (XLEN bits).

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the existing datapath.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction currently in decode; supplies imm16 [15:0] and target26 [25:0].
- branch_op  in  2  00 none, 01 BEQ (taken if zero), 10 BNE (taken if !zero), 11 reserved (treated as none).
- zero  in  1  ALU zero flag.
- jump  in  1  J/JAL pseudo-direct jump.
- jump_reg  in  1  JR; target is rs_data.
- rs_data  in  XLEN  register operand for JR.
- exc_req  in  1  synchronous exception request.
- stall  in  1  hazard stall; holds the PC.
- imem_req_ready  in  1  instruction memory accepts the address.
- imem_req_valid  out  1  address request valid.
- pc  out  XLEN  current fetch address (also the imem address).
- epc  out  XLEN  faulting/interrupted PC captured on an exception.
- misalign_err  out  1  one-cycle pulse: JR target was not word-aligned.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_VECTOR, epc=0, misalign_err=0, imem_req_valid=0.
  - pend_valid=0, pend_target=0, state=IDLE.
- FSM states: IDLE, FETCH.
  - IDLE: first falling edge with reset=1 goes to FETCH and sets imem_req_valid=1. pc stays RESET_VECTOR, so the first request is the reset vector.
  - FETCH: imem_req_valid=1 continuously. There is no return to IDLE except through reset.
- advance = FETCH & imem_req_ready & !stall. pc changes only on an advance edge, so pc is stable whenever valid=1 and ready=0.
- Target arithmetic (all modulo 2^XLEN, wrap silently):
  - pc_inc = pc+4.
  - br_tgt = pc_inc + (sext(imm16)<<2).
  - j_tgt = {pc_inc[XLEN-1:28], target26, 2'b00}.
  - jr_tgt = rs_data.
- Redirect source this cycle, highest priority first:
  1. exc_req → EXC_VECTOR.
  2. jump_reg → jr_tgt.
  3. jump → j_tgt.
  4. taken branch → br_tgt.
- Next pc on advance:
  - If pend_valid: pend_target, and pend_valid clears; an exc_req in the same cycle still wins.
  - Else if a redirect is present: its target.
  - Else: pc_inc.
- Redirect without advance (FETCH & (!imem_req_ready | stall)):
  - If !pend_valid: capture the target into pend_target and set pend_valid.
  - If pend_valid: a non-exception redirect is ignored (older transfer wins). exc_req overwrites pend_target with EXC_VECTOR.
- Exception: on the edge where exc_req is accepted (advanced or buffered), epc <= pc.
- Misaligned JR (rs_data[1:0] != 0 while jump_reg is the winning source):
  - The target is replaced by EXC_VECTOR.
  - epc <= rs_data.
  - misalign_err=1 for exactly one cycle.
  - Buffering and priority apply as for an exception.
- Inputs are ignored in IDLE.
- reset asserted mid-stall or with pend_valid=1 returns immediately to the reset values; the pending target is discarded.

Decomposition:
- Shared package (mips_pkg):
  - branch_op encodings (BR_NONE, BR_EQ, BR_NE).
  - FSM state typedef.
  - INSTR_BYTES=4 constant.
- One combinational sub-module, pc_target_gen, computes pc_inc, br_tgt, j_tgt, the winning redirect target and the misalign flag.
- The FSM, pending buffer and epc register stay in pc_fetch_unit.

Test Plan:
- Reset/first fetch: release reset with imem_req_ready=1 → pc=0x0000_0000 and valid=1 on the first edge; then 0x4, 0x8 on the following edges.
- BEQ/BNE: pc=0x100, imm16=0xFFFE, branch_op=01, zero=1 → pc=0x0FC. Same with zero=1 and branch_op=10 → pc=0x104.
- Back-pressure plus redirect: pc=0x200, ready=0, jump with target26=0x40 for one cycle; ready=1 two cycles later → pc held at 0x200, then 0x100; no lost or duplicate target.
- Pending conflict: ready=0, JR rs_data=0x400 then J in the next cycle; ready=1 → pc=0x400; the J is ignored.
- Misaligned JR: pc=0x300, rs_data=0x402 → pc=0x80, epc=0x402, misalign_err pulses high for exactly 1 cycle.
- Async reset mid-stall with pend_valid=1: pull reset low between edges → pc=RESET_VECTOR, valid=0 and pend_valid=0 immediately, with no clock edge.
